// File: rtl/wb_bfm_responder_if.sv
// Wishbone B4 pipelined bus bundle between a host master and wb_bfm_responder.
// Signal names keep the slave-side direction suffixes of the Wishbone port list.
interface wb_bfm_responder_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [11:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_stall_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
    );
endinterface

// File: rtl/wb_bfm_responder.sv
// Wishbone B4 pipelined register/scratch-RAM responder for host bring-up.
// Four registers (ID, WR_CNT, RD_CNT, CTRL) plus a 64x32 byte-writable scratch
// RAM, one outstanding access, g_wait_states extra cycles before ack.
// Optional feature macro: WB_RESPONDER_ERR_EN -- unmapped accesses end with err
// unless CTRL.ERR_MASK is set; without it err is tied low and ERR_MASK reads 0.
module wb_bfm_responder #(
    parameter logic [31:0] g_id          = 32'h5742_5231,
    parameter int          g_wait_states = 0
) (
    input  logic               clk_sys_i,
    input  logic               rst_i,
    wb_bfm_responder_if.slave  wb
);

    localparam logic [3:0] WS = 4'(g_wait_states);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      state;
    logic [3:0]  wcnt;
    logic [11:2] adr_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] wdat_q;
    logic [31:0] rdat_q;
    logic        ack_q;
    logic        err_q;
    logic        stall_q;
    logic [31:0] wr_cnt;
    logic [31:0] rd_cnt;
    logic        err_mask;
    logic [31:0] ram [0:63];

    // Byte-offset bits are don't-care on this bus.
    logic unused_adr;
    assign unused_adr = ^wb.wb_adr_i[1:0];

    // Decode the address being responded to: the live bus address on the
    // zero-wait accept edge, the latched one otherwise.
    logic [11:2] cur_adr;
    logic        cur_reg, cur_ram, cur_unmapped, resp_err, cur_we;
    logic [31:0] rd_val;

    assign cur_adr      = (state == S_IDLE) ? wb.wb_adr_i[11:2] : adr_q;
    assign cur_we       = (state == S_IDLE) ? wb.wb_we_i : we_q;
    assign cur_reg      = (cur_adr[11:4] == 8'h00);
    assign cur_ram      = (cur_adr[11:8] == 4'h1);
    assign cur_unmapped = !(cur_reg || cur_ram);
`ifdef WB_RESPONDER_ERR_EN
    assign resp_err     = cur_unmapped && !err_mask;
`else
    assign resp_err     = 1'b0;
`endif

    // Read data mux; register reads reflect counter values before this access counts.
    always_comb begin
        rd_val = 32'h0;
        if (cur_reg) begin
            case (cur_adr[3:2])
                2'd0: rd_val = g_id;
                2'd1: rd_val = wr_cnt;
                2'd2: rd_val = rd_cnt;
                default: rd_val = {30'h0, err_mask, 1'b0};
            endcase
        end else if (cur_ram) begin
            rd_val = ram[cur_adr[7:2]];
        end
    end

    logic accept, commit, wr_ram, wr_ctrl, wr_clr;

    assign accept  = (state == S_IDLE) && wb.wb_cyc_i && wb.wb_stb_i;
    // The access takes effect on the edge leaving ACK, only if the master is
    // still in the cycle and the response was an ack.
    assign commit  = (state == S_ACK) && wb.wb_cyc_i && !err_q;
    assign wr_ram  = commit && we_q && (adr_q[11:8] == 4'h1);
    assign wr_ctrl = commit && we_q && (adr_q == 10'h003) && sel_q[0];
    assign wr_clr  = wr_ctrl && wdat_q[0];

    // Bus FSM with registered ack/err/stall/data outputs and access counters.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            wcnt    <= 4'h0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            wdat_q  <= 32'h0;
            rdat_q  <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= 1'b0;
            wr_cnt  <= 32'h0;
            rd_cnt  <= 32'h0;
        end else begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rdat_q <= 32'h0;

            if (wr_clr) begin
                wr_cnt <= 32'h0;
                rd_cnt <= 32'h0;
            end else if (commit && we_q) begin
                wr_cnt <= wr_cnt + 32'h1;
            end else if (commit) begin
                rd_cnt <= rd_cnt + 32'h1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        adr_q   <= wb.wb_adr_i[11:2];
                        we_q    <= wb.wb_we_i;
                        sel_q   <= wb.wb_sel_i;
                        wdat_q  <= wb.wb_dat_i;
                        stall_q <= 1'b1;
                        if (WS == 4'h0) begin
                            state  <= S_ACK;
                            ack_q  <= !resp_err;
                            err_q  <= resp_err;
                            rdat_q <= (cur_we || resp_err) ? 32'h0 : rd_val;
                        end else begin
                            state <= S_WAIT;
                            wcnt  <= WS - 4'h1;
                        end
                    end
                end
                S_WAIT: begin
                    if (!wb.wb_cyc_i) begin
                        state   <= S_IDLE;
                        stall_q <= 1'b0;
                    end else if (wcnt == 4'h0) begin
                        state  <= S_ACK;
                        ack_q  <= !resp_err;
                        err_q  <= resp_err;
                        rdat_q <= (cur_we || resp_err) ? 32'h0 : rd_val;
                    end else begin
                        wcnt <= wcnt - 4'h1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_RESPONDER_ERR_EN
    // ERR_MASK bit of CTRL; CLR is write-only and self-clearing.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i)
            err_mask <= 1'b0;
        else if (wr_ctrl)
            err_mask <= wdat_q[1];
    end
`else
    assign err_mask = 1'b0;
`endif

    // Scratch RAM byte-lane writes; contents survive reset.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_i && wr_ram) begin
            for (int b = 0; b < 4; b++)
                if (sel_q[b])
                    ram[adr_q[7:2]][b*8 +: 8] <= wdat_q[b*8 +: 8];
        end
    end

    // A master that has left the cycle never sees a response.
    assign wb.wb_ack_o   = ack_q && wb.wb_cyc_i;
    assign wb.wb_err_o   = err_q && wb.wb_cyc_i;
    assign wb.wb_stall_o = stall_q;
    assign wb.wb_dat_o   = rdat_q;

endmodule
